// File: rtl/video_pattern_source_pkg.sv
// rtl/video_pattern_source_pkg.sv - shared types and VIP framing constants for the pattern source
package video_stream_pkg;

    typedef enum logic [2:0] {
        MODE_BARS  = 3'd0,
        MODE_HGRAD = 3'd1,
        MODE_CHECK = 3'd2,
        MODE_SOLID = 3'd3,
        MODE_XYCNT = 3'd4
    } mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CTRL,
        ST_DHDR,
        ST_PIX
    } state_e;

    localparam logic [3:0] VIP_TYPE_CTRL   = 4'hF;
    localparam logic [3:0] VIP_TYPE_DATA   = 4'h0;
    localparam logic [3:0] VIP_PROGRESSIVE = 4'h3;

    // Control packet words in beat order: type, width, height, interlace nibble.
    function automatic logic [31:0] vip_ctrl_word(input logic [1:0] idx,
                                                  input logic [15:0] w,
                                                  input logic [15:0] h);
        case (idx)
            2'd0:    return {28'h0, VIP_TYPE_CTRL};
            2'd1:    return {16'h0, w};
            2'd2:    return {16'h0, h};
            default: return {28'h0, VIP_PROGRESSIVE};
        endcase
    endfunction

endpackage

// File: rtl/video_pattern_source_if.sv
// rtl/video_pattern_source_if.sv - ready/valid video stream with packet framing
interface video_pattern_source_if #(
    parameter int DW = 32
) ();
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;
    logic          sop;
    logic          eop;

    modport master (output valid, data, sop, eop, input ready);
    modport slave  (input valid, data, sop, eop, output ready);
endinterface

// File: rtl/video_pattern_source_pixel_gen.sv
// rtl/video_pattern_source_pixel_gen.sv - one-stage registered pattern function of (xs, y, mode)
module vps_pixel_gen
    import video_stream_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int CW         = 8,
    parameter int DW         = 32,
    parameter int CHECK_LOG2 = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [15:0]     i_xs,
    input  logic [15:0]     i_y,
    input  logic [2:0]      i_mode,
    input  logic [3*CW-1:0] i_solid,
    output logic [DW-1:0]   o_data
);
    localparam logic [CW-1:0] MAXC = '1;
    localparam int            PW   = CW + 16;

    logic [2:0]    w_bar;
    logic [PW-1:0] w_prod;
    logic [CW-1:0] w_grad;
    logic [CW-1:0] w_try;
    logic          w_chk;
    logic [DW-1:0] w_data;
    logic [DW-1:0] r_data;

    always_comb begin
        // bar = xs*8/WIDTH found by comparing against constant multiples of WIDTH
        w_bar = '0;
        for (int k = 1; k < 8; k++) begin
            if ({1'b0, i_xs, 3'b000} >= 20'(k * WIDTH)) w_bar = 3'(k);
        end
        // gradient quotient built bit by bit against the constant divisor WIDTH-1
        w_prod = PW'(i_xs) * PW'(MAXC);
        w_grad = '0;
        w_try  = '0;
        for (int b = CW - 1; b >= 0; b--) begin
            w_try    = w_grad;
            w_try[b] = 1'b1;
            if (PW'(w_try) * PW'(WIDTH - 1) <= w_prod) w_grad = w_try;
        end
        w_chk = i_xs[CHECK_LOG2] ^ i_y[CHECK_LOG2];
        case (i_mode)
            MODE_HGRAD: w_data = DW'({w_grad, w_grad, w_grad});
            MODE_CHECK: w_data = w_chk ? DW'({3{MAXC}}) : '0;
            MODE_SOLID: w_data = DW'(i_solid);
            MODE_XYCNT: w_data = DW'({i_y, i_xs});
            default:    w_data = DW'({{CW{w_bar[2]}}, {CW{w_bar[1]}}, {CW{w_bar[0]}}});
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_data <= '0;
        else        r_data <= w_data;
    end

    assign o_data = r_data;
endmodule

// File: rtl/video_pattern_source.sv
// rtl/video_pattern_source.sv - VIP-framed test-pattern source with backpressure and scrolling
module video_pattern_source
    import video_stream_pkg::*;
#(
    parameter int WIDTH      = 160,
    parameter int HEIGHT     = 90,
    parameter int CW         = 8,
    parameter int DW         = 32,
    parameter int CHECK_LOG2 = 3
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic [2:0]             mode,
    input  logic [3*CW-1:0]        solid_rgb,
    input  logic                   scroll_en,
    video_pattern_source_if.master src,
    output logic [15:0]            frame_count,
    output logic                   busy
);
    state_e          r_state, w_state_n;
    logic            r_valid, w_valid_n, r_sop, w_sop_n, r_eop, w_eop_n;
    logic [DW-1:0]   r_data, w_data_n, w_pix;
    logic [1:0]      r_cnt, w_cnt_n;
    logic [15:0]     r_x, w_x_n, r_y, w_y_n, r_off, w_off_n, r_fc, w_fc_n;
    logic            r_busy, w_busy_n, r_scroll, w_scroll_n;
    logic [2:0]      r_mode, w_mode_n;
    logic [3*CW-1:0] r_solid, w_solid_n;
    logic            w_accept, w_last_x, w_last_y;
    logic [16:0]     w_sum;
    logic [15:0]     w_xs;

    assign w_accept = r_valid & src.ready;
    assign w_last_x = (r_x == 16'(WIDTH - 1));
    assign w_last_y = (r_y == 16'(HEIGHT - 1));

    always_comb begin
        w_state_n  = r_state;
        w_valid_n  = r_valid;
        w_sop_n    = r_sop;
        w_eop_n    = r_eop;
        w_data_n   = r_data;
        w_cnt_n    = r_cnt;
        w_x_n      = r_x;
        w_y_n      = r_y;
        w_off_n    = r_off;
        w_fc_n     = r_fc;
        w_busy_n   = r_busy;
        w_scroll_n = r_scroll;
        w_mode_n   = r_mode;
        w_solid_n  = r_solid;
        case (r_state)
            ST_IDLE: if (enable) begin
                w_mode_n   = mode;
                w_solid_n  = solid_rgb;
                w_scroll_n = scroll_en;
                if (!scroll_en) w_off_n = '0;
                w_busy_n   = 1'b1;
                w_valid_n  = 1'b1;
                w_sop_n    = 1'b1;
                w_eop_n    = 1'b0;
                w_data_n   = DW'(vip_ctrl_word(2'd0, 16'(WIDTH), 16'(HEIGHT)));
                w_cnt_n    = 2'd0;
                w_state_n  = ST_CTRL;
            end
            ST_CTRL: if (w_accept) begin
                if (r_cnt == 2'd3) begin
                    w_state_n = ST_DHDR;
                    w_data_n  = DW'(VIP_TYPE_DATA);
                    w_sop_n   = 1'b1;
                    w_eop_n   = 1'b0;
                end else begin
                    w_cnt_n  = r_cnt + 2'd1;
                    w_data_n = DW'(vip_ctrl_word(r_cnt + 2'd1, 16'(WIDTH), 16'(HEIGHT)));
                    w_sop_n  = 1'b0;
                    w_eop_n  = (r_cnt == 2'd2);
                end
            end
            ST_DHDR, ST_PIX: if (w_accept) begin
                if (r_state == ST_PIX && r_eop) begin
                    w_valid_n = 1'b0;
                    w_sop_n   = 1'b0;
                    w_eop_n   = 1'b0;
                    w_fc_n    = r_fc + 16'd1;
                    w_busy_n  = 1'b0;
                    w_state_n = ST_IDLE;
                    if (!r_scroll)    w_off_n = '0;
                    else if (r_off == 16'(WIDTH - 1)) w_off_n = '0;
                    else              w_off_n = r_off + 16'd1;
                end else begin
                    // pixel generator already holds the pixel for (r_x, r_y)
                    w_state_n = ST_PIX;
                    w_data_n  = w_pix;
                    w_sop_n   = 1'b0;
                    w_eop_n   = w_last_x && w_last_y;
                    if (w_last_x) begin
                        w_x_n = '0;
                        w_y_n = w_last_y ? 16'd0 : r_y + 16'd1;
                    end else begin
                        w_x_n = r_x + 16'd1;
                    end
                end
            end
            default: w_state_n = ST_IDLE;
        endcase
    end

    // Feed the generator the post-update coordinate so its output tracks (r_x, r_y).
    assign w_sum = {1'b0, w_x_n} + {1'b0, r_off};
    assign w_xs  = (w_sum >= 17'(WIDTH)) ? 16'(w_sum - 17'(WIDTH)) : w_sum[15:0];

    vps_pixel_gen #(
        .WIDTH(WIDTH), .CW(CW), .DW(DW), .CHECK_LOG2(CHECK_LOG2)
    ) u_pixel_gen (
        .clk     (clk),
        .reset   (reset),
        .i_xs    (w_xs),
        .i_y     (w_y_n),
        .i_mode  (r_mode),
        .i_solid (r_solid),
        .o_data  (w_pix)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_valid  <= 1'b0;
            r_sop    <= 1'b0;
            r_eop    <= 1'b0;
            r_data   <= '0;
            r_cnt    <= '0;
            r_x      <= '0;
            r_y      <= '0;
            r_off    <= '0;
            r_fc     <= '0;
            r_busy   <= 1'b0;
            r_scroll <= 1'b0;
            r_mode   <= MODE_BARS;
            r_solid  <= '0;
        end else begin
            r_state  <= w_state_n;
            r_valid  <= w_valid_n;
            r_sop    <= w_sop_n;
            r_eop    <= w_eop_n;
            r_data   <= w_data_n;
            r_cnt    <= w_cnt_n;
            r_x      <= w_x_n;
            r_y      <= w_y_n;
            r_off    <= w_off_n;
            r_fc     <= w_fc_n;
            r_busy   <= w_busy_n;
            r_scroll <= w_scroll_n;
            r_mode   <= w_mode_n;
            r_solid  <= w_solid_n;
        end
    end

    assign src.valid   = r_valid;
    assign src.data    = r_data;
    assign src.sop     = r_sop;
    assign src.eop     = r_eop;
    assign frame_count = r_fc;
    assign busy        = r_busy;
endmodule

// File: tb/tb_video_pattern_source.sv
// tb/tb_video_pattern_source.sv - directed vector bench for video_pattern_source
module tb_video_pattern_source;

    typedef struct {
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } beat_t;

    typedef struct {
        bit          run;
        logic [2:0]  mode;
        logic [23:0] rgb;
        bit          scroll;
        int          beat;
        logic [31:0] data;
        logic        sop;
        logic        eop;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        s_enable = 1'b0, s_scroll = 1'b0, s_busy;
    logic [2:0]  s_mode = '0;
    logic [23:0] s_rgb = '0;
    logic [15:0] s_fc;
    logic        b_enable = 1'b0, b_busy;
    logic [15:0] b_fc;
    logic        rnd = 1'b0;

    video_pattern_source_if #(.DW(32)) s_if ();
    video_pattern_source_if #(.DW(32)) b_if ();

    video_pattern_source #(.WIDTH(4), .HEIGHT(2), .CW(8), .DW(32), .CHECK_LOG2(1)) u_small (
        .clk(clk), .reset(rst_n), .enable(s_enable), .mode(s_mode), .solid_rgb(s_rgb),
        .scroll_en(s_scroll), .src(s_if.master), .frame_count(s_fc), .busy(s_busy)
    );

    video_pattern_source #(.WIDTH(160), .HEIGHT(90), .CW(8), .DW(32), .CHECK_LOG2(3)) u_big (
        .clk(clk), .reset(rst_n), .enable(b_enable), .mode(3'd0), .solid_rgb(24'h0),
        .scroll_en(1'b0), .src(b_if.master), .frame_count(b_fc), .busy(b_busy)
    );

    int    n_vec = 0;
    int    n_err = 0;
    int    exp_fc_s = 0;
    beat_t q_s[$];
    beat_t q_b[$];
    vec_t  tv[$];
    beat_t exp_solid[13];
    logic  s_stall = 1'b0;
    beat_t s_hold;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic beat_t get_s(input int idx);
        beat_t b;
        b = '{32'hx, 1'bx, 1'bx};
        if (idx < q_s.size()) b = q_s[idx];
        return b;
    endfunction

    function automatic beat_t get_b(input int idx);
        beat_t b;
        b = '{32'hx, 1'bx, 1'bx};
        if (idx < q_b.size()) b = q_b[idx];
        return b;
    endfunction

    initial begin
        s_if.ready = 1'b1;
        b_if.ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            s_if.ready = rnd ? ($urandom_range(0, 9) >= 3) : 1'b1;
        end
    end

    // Capture accepted beats; while stalled, the presented beat must not change.
    always @(negedge clk) begin
        if (rst_n) begin
            if (s_stall) begin
                chk("stall_data", s_if.data, s_hold.data);
                chk("stall_flags", {29'h0, s_if.valid, s_if.sop, s_if.eop}, {29'h0, 1'b1, s_hold.sop, s_hold.eop});
            end
            if (s_if.valid && s_if.ready) q_s.push_back('{s_if.data, s_if.sop, s_if.eop});
            s_stall = s_if.valid && !s_if.ready;
            s_hold  = '{s_if.data, s_if.sop, s_if.eop};
            if (b_if.valid && b_if.ready) q_b.push_back('{b_if.data, b_if.sop, b_if.eop});
        end else begin
            s_stall = 1'b0;
        end
    end

    task automatic run_small(input logic [2:0] m, input logic [23:0] rgb, input bit sc);
        int t;
        q_s.delete();
        @(posedge clk);
        #1;
        s_mode = m; s_rgb = rgb; s_scroll = sc; s_enable = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!s_busy && t < 100);
        chk("busy_rise", {31'h0, s_busy}, 32'd1);
        @(posedge clk);
        #1;
        s_enable = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (s_busy && t < 2000);
        chk("busy_fall", {31'h0, s_busy}, 32'd0);
        exp_fc_s++;
        chk("beat_count", 32'(q_s.size()), 32'd13);
        chk("frame_count", {16'h0, s_fc}, 32'(exp_fc_s));
    endtask

    task automatic add(input bit run, input logic [2:0] m, input logic [23:0] rgb, input bit sc,
                       input int beat, input logic [31:0] d, input logic sop, input logic eop);
        tv.push_back('{run, m, rgb, sc, beat, d, sop, eop});
    endtask

    initial begin
        int    t;
        beat_t b;

        add(1, 3, 24'h123456, 0,  0, 32'h0000000F, 1, 0);
        add(0, 3, 24'h123456, 0,  1, 32'h00000004, 0, 0);
        add(0, 3, 24'h123456, 0,  2, 32'h00000002, 0, 0);
        add(0, 3, 24'h123456, 0,  3, 32'h00000003, 0, 1);
        add(0, 3, 24'h123456, 0,  4, 32'h00000000, 1, 0);
        add(0, 3, 24'h123456, 0,  5, 32'h00123456, 0, 0);
        add(0, 3, 24'h123456, 0, 12, 32'h00123456, 0, 1);
        add(1, 0, 24'h0, 0,  5, 32'h00000000, 0, 0);
        add(0, 0, 24'h0, 0,  6, 32'h0000FF00, 0, 0);
        add(0, 0, 24'h0, 0,  7, 32'h00FF0000, 0, 0);
        add(0, 0, 24'h0, 0,  8, 32'h00FFFF00, 0, 0);
        add(0, 0, 24'h0, 0, 12, 32'h00FFFF00, 0, 1);
        add(1, 1, 24'h0, 0,  6, 32'h00555555, 0, 0);
        add(0, 1, 24'h0, 0,  7, 32'h00AAAAAA, 0, 0);
        add(0, 1, 24'h0, 0,  8, 32'h00FFFFFF, 0, 0);
        add(1, 2, 24'h0, 0,  6, 32'h00000000, 0, 0);
        add(0, 2, 24'h0, 0,  7, 32'h00FFFFFF, 0, 0);
        add(1, 4, 24'h0, 0, 10, 32'h00010001, 0, 0);
        add(0, 4, 24'h0, 0, 12, 32'h00010003, 0, 1);
        add(1, 7, 24'h0, 0,  6, 32'h0000FF00, 0, 0);
        add(1, 4, 24'h0, 1,  5, 32'h00000000, 0, 0);
        add(1, 4, 24'h0, 1,  5, 32'h00000001, 0, 0);
        add(0, 4, 24'h0, 1, 11, 32'h00010003, 0, 0);
        add(1, 4, 24'h0, 1,  5, 32'h00000002, 0, 0);
        add(1, 4, 24'h0, 1,  5, 32'h00000003, 0, 0);
        add(1, 4, 24'h0, 1,  5, 32'h00000000, 0, 0);
        add(1, 4, 24'h0, 0,  5, 32'h00000000, 0, 0);
        add(0, 4, 24'h0, 0,  6, 32'h00000001, 0, 0);

        for (int i = 0; i < 13; i++) exp_solid[i] = '{32'h00123456, 1'b0, 1'b0};
        exp_solid[0] = '{32'hF, 1'b1, 1'b0};
        exp_solid[1] = '{32'h4, 1'b0, 1'b0};
        exp_solid[2] = '{32'h2, 1'b0, 1'b0};
        exp_solid[3] = '{32'h3, 1'b0, 1'b1};
        exp_solid[4] = '{32'h0, 1'b1, 1'b0};
        exp_solid[12].eop = 1'b1;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'h0, s_if.valid}, 32'd0);
        chk("rst_flags", {30'h0, s_if.sop, s_if.eop}, 32'd0);
        chk("rst_data", s_if.data, 32'd0);
        chk("rst_fc", {16'h0, s_fc}, 32'd0);
        chk("rst_busy", {31'h0, s_busy}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        foreach (tv[i]) begin
            if (tv[i].run) run_small(tv[i].mode, tv[i].rgb, tv[i].scroll);
            b = get_s(tv[i].beat);
            chk($sformatf("vec%0d_data", i), b.data, tv[i].data);
            chk($sformatf("vec%0d_flags", i), {30'h0, b.sop, b.eop}, {30'h0, tv[i].sop, tv[i].eop});
        end

        rnd = 1'b1;
        run_small(3, 24'h123456, 0);
        rnd = 1'b0;
        for (int i = 0; i < 13; i++) begin
            b = get_s(i);
            chk($sformatf("bp%0d_data", i), b.data, exp_solid[i].data);
            chk($sformatf("bp%0d_flags", i), {30'h0, b.sop, b.eop}, {30'h0, exp_solid[i].sop, exp_solid[i].eop});
        end

        q_b.delete();
        @(posedge clk);
        #1;
        b_enable = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (q_b.size() < 105 && t < 1000);
        chk("big_pix100", {31'h0, q_b.size() >= 105}, 32'd1);
        @(posedge clk);
        #1;
        b_enable = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (b_busy && t < 20000);
        chk("big_busy_fall", {31'h0, b_busy}, 32'd0);
        chk("big_beats", 32'(q_b.size()), 32'd14405);
        chk("big_x0", get_b(5).data, 32'h00000000);
        chk("big_x20", get_b(25).data, 32'h000000FF);
        chk("big_x159", get_b(164).data, 32'h00FFFFFF);
        chk("big_pre_eop", {31'h0, get_b(14403).eop}, 32'd0);
        chk("big_eop", {31'h0, get_b(14404).eop}, 32'd1);
        chk("big_last", get_b(14404).data, 32'h00FFFFFF);
        chk("big_fc", {16'h0, b_fc}, 32'd1);
        repeat (20) @(negedge clk);
        chk("big_idle_valid", {31'h0, b_if.valid}, 32'd0);
        chk("big_idle_busy", {31'h0, b_busy}, 32'd0);
        chk("big_no_refire", 32'(q_b.size()), 32'd14405);

        q_s.delete();
        @(posedge clk);
        #1;
        s_mode = 3'd4; s_scroll = 1'b0; s_enable = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (q_s.size() < 8 && t < 200);
        chk("mid_pix", {31'h0, q_s.size() >= 8}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        s_enable = 1'b0;
        @(negedge clk);
        chk("abort_valid", {31'h0, s_if.valid}, 32'd0);
        chk("abort_fc", {16'h0, s_fc}, 32'd0);
        chk("abort_busy", {31'h0, s_busy}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        exp_fc_s = 0;
        run_small(3, 24'h123456, 0);
        b = get_s(0);
        chk("post_rst_data", b.data, 32'h0000000F);
        chk("post_rst_sop", {31'h0, b.sop}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
